// File: rtl/snake_pkg.sv
// Shared grid geometry and target-FSM encoding for the snake game blocks.
package snake_pkg;

    localparam int X_WIDTH = 8;
    localparam int Y_WIDTH = 7;

    localparam logic [X_WIDTH-1:0] X_MAX = 8'd159;
    localparam logic [Y_WIDTH-1:0] Y_MAX = 7'd119;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        ARMED = 2'd2,
        EATEN = 2'd3
    } tgt_state_e;

    function automatic logic on_grid(input logic [X_WIDTH-1:0] x,
                                     input logic [Y_WIDTH-1:0] y);
        return (x <= X_MAX) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/target_generator_lfsr15.sv
// Free-running 15-bit Fibonacci LFSR (x^15 + x^14 + 1), maximal length 32767.
module lfsr15 #(
    parameter logic [14:0] SEED = 15'h0001
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [14:0] Q
);

    logic [14:0] lfsr_q;
    logic [14:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign Q = lfsr_q;

endmodule

// File: rtl/target_generator.sv
// Snake target placer and eat detector; TARGET_ATE is stretched to ATE_HOLD cycles.
// Optional relocation of an uneaten target is enabled by defining TARGET_TIMEOUT_EN.
module target_generator
    import snake_pkg::*;
#(
    parameter int unsigned ATE_HOLD  = 100000,
    parameter logic [14:0] LFSR_SEED = 15'h0001,
    parameter int unsigned TIMEOUT   = 500000000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               HEAD_VALID,
    input  logic [X_WIDTH-1:0] HEAD_X,
    input  logic [Y_WIDTH-1:0] HEAD_Y,
    output logic [X_WIDTH-1:0] TARGET_X,
    output logic [Y_WIDTH-1:0] TARGET_Y,
    output logic               TARGET_VAL,
    output logic               TARGET_ATE
);

    localparam int HOLD_W = $clog2(ATE_HOLD + 1);

    tgt_state_e         state_q, state_d;
    logic [X_WIDTH-1:0] target_x_q, target_x_d;
    logic [Y_WIDTH-1:0] target_y_q, target_y_d;
    logic               val_q, val_d;
    logic               ate_q, ate_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

`ifdef TARGET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    tmo_q, tmo_d;
`endif

    logic [14:0]        lfsr;
    logic [X_WIDTH-1:0] cand_x;
    logic [Y_WIDTH-1:0] cand_y;
    logic               cand_ok;
    logic               hit;

    lfsr15 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .Q     (lfsr)
    );

    assign cand_x = lfsr[7:0];
    assign cand_y = lfsr[14:8];

    // A candidate under the head would be eaten instantly, so it is rejected.
    assign cand_ok = on_grid(cand_x, cand_y) &&
                     !((cand_x == HEAD_X) && (cand_y == HEAD_Y));

    assign hit = HEAD_VALID && (HEAD_X == target_x_q) && (HEAD_Y == target_y_q);

    always_comb begin
        state_d    = state_q;
        target_x_d = target_x_q;
        target_y_d = target_y_q;
        val_d      = val_q;
        ate_d      = ate_q;
        hold_d     = hold_q;
`ifdef TARGET_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                state_d = PLACE;
            end
            PLACE: begin
                if (cand_ok) begin
                    target_x_d = cand_x;
                    target_y_d = cand_y;
                    val_d      = 1'b1;
                    state_d    = ARMED;
`ifdef TARGET_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            ARMED: begin
                if (hit) begin
                    ate_d   = 1'b1;
                    val_d   = 1'b0;
                    hold_d  = HOLD_W'(ATE_HOLD - 1);
                    state_d = EATEN;
`ifdef TARGET_TIMEOUT_EN
                end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                    val_d   = 1'b0;
                    state_d = PLACE;
                end else begin
                    tmo_d   = tmo_q + TO_W'(1);
`endif
                end
            end
            EATEN: begin
                if (hold_q == '0) begin
                    ate_d   = 1'b0;
                    state_d = PLACE;
                end else begin
                    hold_d  = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Leaving PLAY overrides everything, including a hit on this cycle.
        if (!ENABLE) begin
            state_d = IDLE;
            val_d   = 1'b0;
            ate_d   = 1'b0;
            hold_d  = '0;
`ifdef TARGET_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            target_x_q <= '0;
            target_y_q <= '0;
            val_q      <= 1'b0;
            ate_q      <= 1'b0;
            hold_q     <= '0;
`ifdef TARGET_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            target_x_q <= target_x_d;
            target_y_q <= target_y_d;
            val_q      <= val_d;
            ate_q      <= ate_d;
            hold_q     <= hold_d;
`ifdef TARGET_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign TARGET_X   = target_x_q;
    assign TARGET_Y   = target_y_q;
    assign TARGET_VAL = val_q;
    assign TARGET_ATE = ate_q;

endmodule

// File: tb/tb_target_generator.sv
// Directed bench for target_generator with ATE_HOLD=8, TIMEOUT=64, LFSR_SEED=1.
module tb_target_generator;
    import snake_pkg::*;

    logic       CLK        = 1'b0;
    logic       RESET      = 1'b0;
    logic       ENABLE     = 1'b0;
    logic       HEAD_VALID = 1'b0;
    logic [7:0] HEAD_X     = 8'd0;
    logic [6:0] HEAD_Y     = 7'd0;
    logic [7:0] TARGET_X;
    logic [6:0] TARGET_Y;
    logic       TARGET_VAL;
    logic       TARGET_ATE;

    int tests = 0;
    int fails = 0;

    // Reference LFSR: m_prev is the candidate tested at the most recent edge.
    logic [14:0] m_lfsr;
    logic [14:0] m_prev;

    target_generator #(
        .ATE_HOLD  (8),
        .LFSR_SEED (15'h0001),
        .TIMEOUT   (64)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .HEAD_VALID (HEAD_VALID),
        .HEAD_X     (HEAD_X),
        .HEAD_Y     (HEAD_Y),
        .TARGET_X   (TARGET_X),
        .TARGET_Y   (TARGET_Y),
        .TARGET_VAL (TARGET_VAL),
        .TARGET_ATE (TARGET_ATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_lfsr <= 15'h0001;
            m_prev <= 15'h0001;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic place_wait(input bit block_first, output bit ok);
        bit blk;
        blk = 1'b0;
        ok  = 1'b0;
        for (int n = 0; n < 40000; n++) begin
            if (n == 1 && blk) begin
                tests++;
                if (TARGET_VAL !== 1'b0) begin
                    fails++;
                    $display("FAIL head_block: accepted candidate under head (%0d,%0d)", HEAD_X, HEAD_Y);
                end
            end
            if (TARGET_VAL === 1'b1) begin
                ok = 1'b1;
                break;
            end
            HEAD_VALID = 1'b0;
            if (n == 0 && block_first) begin
                HEAD_X = m_lfsr[7:0];
                HEAD_Y = m_lfsr[14:8];
                blk    = (m_lfsr[7:0] <= 8'd159) && (m_lfsr[14:8] <= 7'd119);
            end else begin
                HEAD_X = 8'($urandom_range(0, 159));
                HEAD_Y = 7'($urandom_range(0, 119));
            end
            @(negedge CLK);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL place_timeout: TARGET_VAL=%b after 40000 cycles, want 1", TARGET_VAL);
        end
        if (ok) begin
            tests++;
            if (TARGET_X > 8'd159 || TARGET_Y > 7'd119) begin
                fails++;
                $display("FAIL place_range: got (%0d,%0d), want x<=159 y<=119", TARGET_X, TARGET_Y);
            end
            tests++;
            if (TARGET_X == HEAD_X && TARGET_Y == HEAD_Y) begin
                fails++;
                $display("FAIL place_head: target (%0d,%0d) equals head", TARGET_X, TARGET_Y);
            end
            tests++;
            if (TARGET_X !== m_prev[7:0] || TARGET_Y !== m_prev[14:8]) begin
                fails++;
                $display("FAIL place_lfsr: got (%0d,%0d), want (%0d,%0d)",
                         TARGET_X, TARGET_Y, m_prev[7:0], m_prev[14:8]);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; ENABLE = 1'b0; HEAD_VALID = 1'b0; HEAD_X = 8'd0; HEAD_Y = 7'd0;
        repeat (3) @(negedge CLK);
        tests++;
        if ({TARGET_X, TARGET_Y, TARGET_VAL, TARGET_ATE} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs: got x=%0d y=%0d val=%b ate=%b, want all 0",
                     TARGET_X, TARGET_Y, TARGET_VAL, TARGET_ATE);
        end
        RESET = 1'b1; ENABLE = 1'b1;
        @(negedge CLK);
        tests++;
        if (TARGET_VAL !== 1'b0) begin
            fails++;
            $display("FAIL first_idle: TARGET_VAL=%b one cycle after enable, want 0", TARGET_VAL);
        end
        @(negedge CLK);
        tests++;
        if (TARGET_VAL !== 1'b1 || TARGET_X !== 8'd2 || TARGET_Y !== 7'd0) begin
            fails++;
            $display("FAIL first_place: got val=%b (%0d,%0d), want val=1 (2,0)",
                     TARGET_VAL, TARGET_X, TARGET_Y);
        end
        HEAD_X = 8'd2; HEAD_Y = 7'd0; HEAD_VALID = 1'b1;
        @(negedge CLK);
        HEAD_VALID = 1'b0; HEAD_X = 8'd0;
        tests++;
        if (TARGET_ATE !== 1'b1) begin
            fails++;
            $display("FAIL first_eat: TARGET_ATE=%b, want 1", TARGET_ATE);
        end
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        tests++;
        if ({TARGET_X, TARGET_Y, TARGET_VAL, TARGET_ATE} !== 17'd0) begin
            fails++;
            $display("FAIL async_reset: got x=%0d y=%0d val=%b ate=%b, want all 0 before clock",
                     TARGET_X, TARGET_Y, TARGET_VAL, TARGET_ATE);
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        tests++;
        if (TARGET_VAL !== 1'b0 || TARGET_ATE !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: val=%b ate=%b, want 0 0", TARGET_VAL, TARGET_ATE);
        end
        @(negedge CLK);
        tests++;
        if (TARGET_VAL !== 1'b1 || TARGET_X !== 8'd2 || TARGET_Y !== 7'd0) begin
            fails++;
            $display("FAIL post_reset_place: got val=%b (%0d,%0d), want val=1 (2,0)",
                     TARGET_VAL, TARGET_X, TARGET_Y);
        end
    endtask

    task automatic test_placement();
        bit         ok;
        bit         val_seen;
        int         cnt;
        logic [7:0] tx;
        logic [6:0] ty;
        for (int it = 0; it < 1000; it++) begin
            tx = TARGET_X; ty = TARGET_Y;
            HEAD_X = tx; HEAD_Y = ty; HEAD_VALID = 1'b1;
            @(negedge CLK);
            cnt = 0; val_seen = 1'b0;
            while (TARGET_ATE === 1'b1 && cnt < 20) begin
                if (TARGET_VAL !== 1'b0) val_seen = 1'b1;
                HEAD_VALID = (it % 2 == 1);
                cnt++;
                @(negedge CLK);
            end
            HEAD_VALID = 1'b0;
            tests++;
            if (cnt != 8) begin
                fails++;
                $display("FAIL pulse_len: iter %0d TARGET_ATE high %0d cycles, want 8", it, cnt);
            end
            tests++;
            if (val_seen) begin
                fails++;
                $display("FAIL val_in_eaten: iter %0d TARGET_VAL=1 during pulse, want 0", it);
            end
            place_wait(it % 2 == 1, ok);
            if (!ok) break;
        end
    endtask

    task automatic test_no_hit();
        logic [7:0] tx;
        logic [6:0] ty;
        tx = TARGET_X; ty = TARGET_Y;
        HEAD_X = tx; HEAD_Y = ty; HEAD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        tests++;
        if (TARGET_ATE !== 1'b0 || TARGET_VAL !== 1'b1) begin
            fails++;
            $display("FAIL nohit_invalid: ate=%b val=%b, want 0 1", TARGET_ATE, TARGET_VAL);
        end
        HEAD_X = tx ^ 8'h80; HEAD_Y = ty; HEAD_VALID = 1'b1;
        @(negedge CLK);
        tests++;
        if (TARGET_ATE !== 1'b0 || TARGET_VAL !== 1'b1) begin
            fails++;
            $display("FAIL nohit_xmsb: ate=%b val=%b, want 0 1", TARGET_ATE, TARGET_VAL);
        end
        HEAD_X = tx; HEAD_Y = ty ^ 7'h40;
        @(negedge CLK);
        tests++;
        if (TARGET_ATE !== 1'b0 || TARGET_VAL !== 1'b1) begin
            fails++;
            $display("FAIL nohit_ymsb: ate=%b val=%b, want 0 1", TARGET_ATE, TARGET_VAL);
        end
        HEAD_X = tx ^ 8'h01; HEAD_Y = ty ^ 7'h01;
        @(negedge CLK);
        HEAD_VALID = 1'b0;
        tests++;
        if (TARGET_ATE !== 1'b0 || TARGET_VAL !== 1'b1 || TARGET_X !== tx || TARGET_Y !== ty) begin
            fails++;
            $display("FAIL nohit_both: ate=%b val=%b (%0d,%0d), want 0 1 (%0d,%0d)",
                     TARGET_ATE, TARGET_VAL, TARGET_X, TARGET_Y, tx, ty);
        end
    endtask

    task automatic test_enable_drop();
        bit         ok;
        logic [7:0] tx;
        logic [6:0] ty;
        tx = TARGET_X; ty = TARGET_Y;
        HEAD_X = tx; HEAD_Y = ty; HEAD_VALID = 1'b1; ENABLE = 1'b0;
        @(negedge CLK);
        HEAD_VALID = 1'b0;
        tests++;
        if (TARGET_ATE !== 1'b0 || TARGET_VAL !== 1'b0) begin
            fails++;
            $display("FAIL enable_drop_hit: ate=%b val=%b, want 0 0", TARGET_ATE, TARGET_VAL);
        end
        tests++;
        if (TARGET_X !== tx || TARGET_Y !== ty) begin
            fails++;
            $display("FAIL enable_drop_xy: got (%0d,%0d), want (%0d,%0d)", TARGET_X, TARGET_Y, tx, ty);
        end
        repeat (5) @(negedge CLK);
        tests++;
        if (TARGET_ATE !== 1'b0 || TARGET_VAL !== 1'b0 || TARGET_X !== tx || TARGET_Y !== ty) begin
            fails++;
            $display("FAIL idle_hold: ate=%b val=%b (%0d,%0d), want 0 0 (%0d,%0d)",
                     TARGET_ATE, TARGET_VAL, TARGET_X, TARGET_Y, tx, ty);
        end
        ENABLE = 1'b1;
        @(negedge CLK);
        place_wait(1'b0, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        bit ate_seen;
`ifdef TARGET_TIMEOUT_EN
        cnt = 0; ate_seen = 1'b0;
        while (TARGET_VAL === 1'b1 && cnt < 200) begin
            if (TARGET_ATE !== 1'b0) ate_seen = 1'b1;
            cnt++;
            @(negedge CLK);
        end
        tests++;
        if (cnt != 64) begin
            fails++;
            $display("FAIL timeout_len: TARGET_VAL held %0d cycles, want 64", cnt);
        end
        tests++;
        if (ate_seen || TARGET_ATE !== 1'b0) begin
            fails++;
            $display("FAIL timeout_ate: TARGET_ATE rose on timeout, want 0");
        end
        place_wait(1'b0, ok);
        if (ok) begin
            repeat (63) @(negedge CLK);
            tests++;
            if (TARGET_VAL !== 1'b1) begin
                fails++;
                $display("FAIL timeout_c63_val: TARGET_VAL=%b on cycle 63, want 1", TARGET_VAL);
            end
            HEAD_X = TARGET_X; HEAD_Y = TARGET_Y; HEAD_VALID = 1'b1;
            @(negedge CLK);
            HEAD_VALID = 1'b0;
            tests++;
            if (TARGET_ATE !== 1'b1) begin
                fails++;
                $display("FAIL timeout_c63_hit: TARGET_ATE=%b, want 1", TARGET_ATE);
            end
        end
`else
        ok = 1'b1;
        cnt = 0; ate_seen = 1'b0;
        while (TARGET_VAL === 1'b1 && cnt < 200) begin
            if (TARGET_ATE !== 1'b0) ate_seen = 1'b1;
            cnt++;
            @(negedge CLK);
        end
        tests++;
        if (cnt != 200 || ate_seen) begin
            fails++;
            $display("FAIL no_timeout: TARGET_VAL held %0d cycles ate_seen=%b, want 200 0", cnt, ate_seen);
        end
        HEAD_X = TARGET_X; HEAD_Y = TARGET_Y; HEAD_VALID = ok;
        @(negedge CLK);
        HEAD_VALID = 1'b0;
        tests++;
        if (TARGET_ATE !== 1'b1) begin
            fails++;
            $display("FAIL late_hit: TARGET_ATE=%b after long armed period, want 1", TARGET_ATE);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_placement();
        test_no_hit();
        test_enable_drop();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
